// File: rtl/iq_sample_repeater_if.sv
// I/Q sample stream bundle: one accepted input sample becomes a run of output beats.
// Both channels use valid/ready. A transfer happens on a clock edge where valid and ready are both high.
// The source holds valid and its payload steady until that transfer. ready may never depend on valid.
interface iq_sample_repeater_if #(
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_i;
  logic [DATA_W-1:0] in_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_i;
  logic [DATA_W-1:0] out_q;
  logic              out_first;
  logic              out_last;

  modport master (
    output in_valid, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_i, out_q, out_first, out_last
  );

  modport slave (
    input  in_valid, in_i, in_q, out_ready,
    output in_ready, out_valid, out_i, out_q, out_first, out_last
  );
endinterface

// File: rtl/iq_sample_repeater.sv
// I/Q interpolation front-end. Each accepted sample is emitted as a run of beats.
// Within a run the sample is either held or followed by exact zeros. Runs stream back-to-back with no bubbles.
module iq_sample_repeater #(
  parameter int DATA_W     = 12,
  parameter int MAX_FACTOR = 16,
  localparam int FW        = $clog2(MAX_FACTOR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] cfg_factor,
  input  logic          cfg_zstuff,
  iq_sample_repeater_if.slave bus
);

  logic              valid_q;
  logic [DATA_W-1:0] i_q;
  logic [DATA_W-1:0] q_q;
  logic [FW-1:0]     rep_cnt;
  logic [FW-1:0]     fac_q;
  logic              mode_q;

  logic [FW-1:0]     eff_factor;
  logic              last;
  logic              in_fire;
  logic              out_fire;

  // A factor of 0 means 1. Anything above MAX_FACTOR saturates.
  always_comb begin
    eff_factor = cfg_factor;
    if (cfg_factor == '0)
      eff_factor = FW'(1);
    else if (cfg_factor > FW'(MAX_FACTOR))
      eff_factor = FW'(MAX_FACTOR);
  end

  assign last     = valid_q && (rep_cnt == fac_q - FW'(1));
  assign out_fire = valid_q && bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;

  // Accept the next sample during the last beat of the current run. This keeps the output stream dense.
  assign bus.in_ready  = !valid_q || (bus.out_ready && last);

  assign bus.out_valid = valid_q;
  assign bus.out_i     = i_q;
  assign bus.out_q     = q_q;
  assign bus.out_first = valid_q && (rep_cnt == '0);
  assign bus.out_last  = last;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
      rep_cnt <= '0;
      fac_q   <= FW'(1);
      mode_q  <= 1'b0;
    end else if (in_fire) begin
      // Configuration is captured only here, so a run in flight is unaffected by later changes.
      valid_q <= 1'b1;
      i_q     <= bus.in_i;
      q_q     <= bus.in_q;
      rep_cnt <= '0;
      fac_q   <= eff_factor;
      mode_q  <= cfg_zstuff;
    end else if (out_fire) begin
      if (!last) begin
        rep_cnt <= rep_cnt + FW'(1);
        if (mode_q) begin
          i_q <= '0;
          q_q <= '0;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iq_sample_repeater.sv
// Bench for iq_sample_repeater. A scoreboard expands each accepted sample into its expected beats.
// Scenario tasks add inline checks on handshake timing, stalls, clamping and reset.
module tb_iq_sample_repeater;
  localparam int DATA_W     = 12;
  localparam int MAX_FACTOR = 16;
  localparam int FW         = $clog2(MAX_FACTOR + 1);
  localparam int W          = 2 + 2 * DATA_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] cfg_factor = FW'(1);
  logic          cfg_zstuff = 1'b0;
  logic          rand_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;
  logic [W-1:0] stall_val;
  logic         stall_prev = 1'b0;

  iq_sample_repeater_if #(.DATA_W(DATA_W)) bus ();

  iq_sample_repeater #(.DATA_W(DATA_W), .MAX_FACTOR(MAX_FACTOR)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_factor (cfg_factor),
    .cfg_zstuff (cfg_zstuff),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  assign cur = {bus.out_first, bus.out_last, bus.out_i, bus.out_q};

  function automatic int eff(input int f);
    if (f == 0) return 1;
    if (f > MAX_FACTOR) return MAX_FACTOR;
    return f;
  endfunction

  task automatic push_sample(input logic [DATA_W-1:0] si, input logic [DATA_W-1:0] sq);
    int f;
    logic [DATA_W-1:0] di, dq;
    f = eff(int'(cfg_factor));
    for (int k = 0; k < f; k++) begin
      di = (cfg_zstuff && k > 0) ? '0 : si;
      dq = (cfg_zstuff && k > 0) ? '0 : sq;
      exp_q.push_back({(k == 0), (k == f - 1), di, dq});
    end
  endtask

  // Presents one sample and returns just after the edge that accepts it. in_valid is left high.
  task automatic send(input logic [DATA_W-1:0] si, input logic [DATA_W-1:0] sq);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_i = si;
    bus.in_q = sq;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        push_sample(si, sq);
        done = 1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: in_ready got %b, required 1 within 100 cycles", bus.in_ready);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still expected, required 0", exp_q.size());
    end
  endtask

  // Scoreboard plus stall-stability monitor. It samples mid-cycle, away from the active edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (cur !== stall_val || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_stable: got v=%b beat=%h, required v=1 beat=%h", bus.out_valid, cur, stall_val);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h, required no beat", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat: got {first,last,i,q}=%h, required %h", cur, e);
          end
        end
      end
      stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      stall_val  = cur;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_i !== '0 || bus.out_q !== '0) begin
      errors++;
      $display("FAIL reset_out: got v=%b i=%h q=%h, required 0 0 0", bus.out_valid, bus.out_i, bus.out_q);
    end
    checks++;
    if (bus.out_first !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got first=%b last=%b, required 0 0", bus.out_first, bus.out_last);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_hold8();
    @(posedge clk); #1;
    cfg_factor = FW'(8);
    cfg_zstuff = 1'b0;
    send(12'h123, 12'hF05);
    bus.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== (b == 7)) begin
        errors++;
        $display("FAIL hold8_in_ready beat %0d: got v=%b rdy=%b, required v=1 rdy=%b",
                 b, bus.out_valid, bus.in_ready, (b == 7));
      end
    end
    drain();
  endtask

  task automatic test_zstuff_back_to_back();
    @(posedge clk); #1;
    cfg_factor = FW'(4);
    cfg_zstuff = 1'b1;
    fork
      begin
        send(12'd5, -12'sd5);
        send(12'd7, -12'sd7);
        bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        for (int b = 0; b < 9; b++) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== (b < 8)) begin
            errors++;
            $display("FAIL zstuff_dense cycle %0d: got v=%b, required %b", b, bus.out_valid, (b < 8));
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_factor1_ramp();
    @(posedge clk); #1;
    cfg_factor = '0;
    cfg_zstuff = 1'b0;
    send(12'h0AA, 12'h055);
    bus.in_valid = 1'b0;
    drain();
    cfg_factor = FW'(1);
    fork
      begin
        for (int k = 0; k < 16; k++) send(12'(k * 17), 12'(12'hFFF - k));
        bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        for (int b = 0; b < 16; b++) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_first !== 1'b1 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL ramp_pass cycle %0d: got v=%b f=%b l=%b, required 1 1 1",
                     b, bus.out_valid, bus.out_first, bus.out_last);
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_random_stall();
    @(posedge clk); #1;
    cfg_factor = FW'(3);
    cfg_zstuff = 1'b0;
    rand_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cfg_zstuff = 1'($urandom_range(0, 1));
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end
    bus.in_valid = 1'b0;
    drain();
    rand_en = 1'b0;
    bus.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_cfg_midburst();
    @(posedge clk); #1;
    cfg_factor = FW'(4);
    cfg_zstuff = 1'b0;
    send(12'h3C1, 12'h0E2);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    cfg_factor = FW'(2);
    cfg_zstuff = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0 || bus.out_first !== 1'b0) begin
      errors++;
      $display("FAIL midburst_rep1: got v=%b f=%b l=%b, required 1 0 0",
               bus.out_valid, bus.out_first, bus.out_last);
    end
    @(posedge clk); #1;
    send(12'h456, 12'h789);
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_clamp();
    int beats;
    @(posedge clk); #1;
    cfg_factor = FW'(20);
    cfg_zstuff = 1'b0;
    send(12'h7FF, 12'h800);
    bus.in_valid = 1'b0;
    beats = 0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) beats++;
    end
    checks++;
    if (beats != 16) begin
      errors++;
      $display("FAIL clamp_beats: got %0d, required 16", beats);
    end
    drain();
  endtask

  task automatic test_reset_midburst();
    @(posedge clk); #1;
    cfg_factor = FW'(8);
    cfg_zstuff = 1'b0;
    send(12'h5A5, 12'hA5A);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_i !== '0 || bus.out_q !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midburst: got v=%b i=%h q=%h rdy=%b, required 0 0 0 1",
               bus.out_valid, bus.out_i, bus.out_q, bus.in_ready);
    end
    @(posedge clk); #1;
    send(12'h111, 12'h222);
    bus.in_valid = 1'b0;
    drain();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_hold8();
    test_zstuff_back_to_back();
    test_factor1_ramp();
    test_random_stall();
    test_cfg_midburst();
    test_clamp();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
